// File: rtl/uart_rx_param_if.sv
// ============================================================================
//  Module   : uart_rx_param_if
//  Brief    : Line-side strobe/serial inputs and frame result outputs of the
//             oversampling UART receiver.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 b_tick;
    logic                 rx;
    logic                 o_rx_done;
    logic [DATA_BITS-1:0] o_dout;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_break;

    // master drives the line and tick, slave is the receiver
    modport master (
        output b_tick, rx,
        input  o_rx_done, o_dout, o_parity_err, o_frame_err, o_break
    );

    modport slave (
        input  b_tick, rx,
        output o_rx_done, o_dout, o_parity_err, o_frame_err, o_break
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
//  Module   : uart_rx_param
//  Brief    : Parameterized oversampling UART receiver with 3-sample majority
//             vote, optional parity, 1/2 stop bits and break detection.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_rx_param_if.slave bus
);
    localparam int                 c_CNT_W    = $clog2(OVERSAMPLE);
    localparam int                 c_BIT_W    = $clog2(DATA_BITS);
    localparam int                 c_H        = OVERSAMPLE / 2;
    localparam logic [c_CNT_W-1:0] c_SMP_A    = c_CNT_W'(c_H - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_B    = c_CNT_W'(c_H);
    localparam logic [c_CNT_W-1:0] c_DEC      = c_CNT_W'(c_H + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_ODD      = (PARITY_ODD != 0);
    localparam logic               c_PAR_EN   = (PARITY_EN != 0);
    localparam logic               c_ONE_STOP = (STOP_BITS == 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_sync;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par_err;
    logic                 r_stop_err;
    logic                 r_all_zero;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_brk_o;

    logic w_rxs;
    logic w_tick;
    logic w_at_dec;
    logic w_at_last;
    logic w_vote;
    logic w_last_stop;
    logic w_is_break;
    logic w_frame_end;

    assign w_rxs       = r_sync[1];
    assign w_tick      = bus.b_tick;
    assign w_at_dec    = w_tick && (r_cnt == c_DEC);
    assign w_at_last   = w_tick && (r_cnt == c_CNT_LAST);
    assign w_vote      = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rxs) | (r_smp[1] & w_rxs);
    assign w_last_stop = c_ONE_STOP || r_stop_idx;
    // r_all_zero covers data, parity and earlier stop bits; w_vote is the final stop
    assign w_is_break  = r_all_zero && !w_vote;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rxs) w_state_next = S_START;
            end
            S_START: begin
                if (w_at_dec && w_vote)  w_state_next = S_IDLE;
                else if (w_at_last)      w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_at_last && (r_bit_idx == c_BIT_LAST))
                    w_state_next = c_PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_at_last) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_at_dec && w_last_stop) begin
                    w_frame_end  = 1'b1;
                    w_state_next = w_is_break ? S_BRK_WAIT : S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                if (w_tick && w_rxs) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_smp      <= 2'b11;
            r_shreg    <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_all_zero <= 1'b0;
            r_done     <= 1'b0;
            r_dout     <= '0;
            r_perr_o   <= 1'b0;
            r_ferr_o   <= 1'b0;
            r_brk_o    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                if (r_state == S_IDLE || r_state == S_BRK_WAIT) begin
                    r_cnt <= '0;
                    if (r_state == S_IDLE && !w_rxs) begin
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end else begin
                    r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                    if (r_cnt == c_SMP_A) r_smp[0] <= w_rxs;
                    if (r_cnt == c_SMP_B) r_smp[1] <= w_rxs;
                end
            end

            if (w_at_dec) begin
                unique case (r_state)
                    S_DATA: begin
                        r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
                        if (w_vote) r_all_zero <= 1'b0;
                    end
                    S_PARITY: begin
                        r_par_err <= ((^r_shreg) ^ w_vote) != c_ODD;
                        if (w_vote) r_all_zero <= 1'b0;
                    end
                    S_STOP: begin
                        if (!w_vote) r_stop_err <= 1'b1;
                        else         r_all_zero <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (w_at_last) begin
                if (r_state == S_DATA)
                    r_bit_idx <= (r_bit_idx == c_BIT_LAST) ? '0 : r_bit_idx + 1'b1;
                if (r_state == S_STOP)
                    r_stop_idx <= 1'b1;
            end

            if (w_frame_end) begin
                r_done   <= 1'b1;
                r_dout   <= r_shreg;
                r_perr_o <= r_par_err;
                r_ferr_o <= r_stop_err | !w_vote;
                r_brk_o  <= w_is_break;
            end
        end
    end

    assign bus.o_rx_done    = r_done;
    assign bus.o_dout       = r_dout;
    assign bus.o_parity_err = r_perr_o;
    assign bus.o_frame_err  = r_ferr_o;
    assign bus.o_break      = r_brk_o;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
//  Module   : tb_uart_rx_param
//  Brief    : Self-checking bench for uart_rx_param (8N1, 8E1 and 7O2/x8).
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rx_c = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   dn_a = 0;
    int   dn_b = 0;
    int   dn_c = 0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();
    uart_rx_param_if #(.DATA_BITS(7)) if_c ();

    assign if_a.b_tick = tick;
    assign if_b.b_tick = tick;
    assign if_c.b_tick = tick;
    assign if_a.rx     = rx_a;
    assign if_b.rx     = rx_b;
    assign if_c.rx     = rx_c;

    uart_rx_param dut_a (.clk(clk), .rst(rst), .bus(if_a));

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // one-clk tick every third clock, changed on the falling edge
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            tick = (div == 0);
            div  = (div + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (if_a.o_rx_done) dn_a = dn_a + 1;
        if (if_b.o_rx_done) dn_b = dn_b + 1;
        if (if_c.o_rx_done) dn_c = dn_c + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_line(input int idx, input logic v);
        case (idx)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic get_out(input int idx, output logic [31:0] n, output logic [31:0] d,
                           output logic [31:0] pe, output logic [31:0] fe, output logic [31:0] br);
        case (idx)
            0: begin n = dn_a; d = 32'(if_a.o_dout); pe = 32'(if_a.o_parity_err);
                     fe = 32'(if_a.o_frame_err); br = 32'(if_a.o_break); end
            1: begin n = dn_b; d = 32'(if_b.o_dout); pe = 32'(if_b.o_parity_err);
                     fe = 32'(if_b.o_frame_err); br = 32'(if_b.o_break); end
            default: begin n = dn_c; d = 32'(if_c.o_dout); pe = 32'(if_c.o_parity_err);
                     fe = 32'(if_c.o_frame_err); br = 32'(if_c.o_break); end
        endcase
    endtask

    task automatic send_frame(input int idx, input int data, input int nb, input int os,
                              input bit pen, input bit pbit, input int nstop, input bit [1:0] stops);
        set_line(idx, 1'b0);
        wait_ticks(os);
        for (int i = 0; i < nb; i++) begin
            set_line(idx, data[i]);
            wait_ticks(os);
        end
        if (pen) begin
            set_line(idx, pbit);
            wait_ticks(os);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(idx, stops[s]);
            wait_ticks(os);
        end
        set_line(idx, 1'b1);
    endtask

    // Reference: frame fields -> expected result from parity counting and zero tests
    task automatic verify(input int idx, input string tag, input int prev, input int data,
                          input int nb, input bit pen, input bit podd, input bit pbit,
                          input int nstop, input bit [1:0] stops);
        logic [31:0] n, d, pe, fe, br;
        int  ones;
        bit  e_pe, e_fe, e_br, any_stop0, all_stop0;
        ones      = $countones(data & ((1 << nb) - 1));
        e_pe      = pen ? (((ones + int'(pbit)) % 2) != int'(podd)) : 1'b0;
        any_stop0 = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        all_stop0 = (stops[0] == 1'b0) && (nstop == 1 || stops[1] == 1'b0);
        e_br      = (ones == 0) && (!pen || !pbit) && all_stop0;
        e_fe      = any_stop0 || e_br;
        get_out(idx, n, d, pe, fe, br);
        check({tag, "_done"}, n, 32'(prev + 1));
        check({tag, "_dout"}, d, 32'(data & ((1 << nb) - 1)));
        check({tag, "_perr"}, pe, 32'(e_pe));
        check({tag, "_ferr"}, fe, 32'(e_fe));
        check({tag, "_brk"},  br, 32'(e_br));
    endtask

    initial begin
        logic [31:0] n, d, pe, fe, br;
        int p, dat;
        bit pb;
        bit [1:0] st;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_done_a", 32'(if_a.o_rx_done), 0);
        check("rst_dout_a", 32'(if_a.o_dout), 0);
        check("rst_flags_a", {29'd0, if_a.o_parity_err, if_a.o_frame_err, if_a.o_break}, 0);
        check("rst_dout_b", 32'(if_b.o_dout), 0);
        check("rst_dout_c", 32'(if_c.o_dout), 0);
        @(posedge clk); #1 rst = 1'b1;
        wait_ticks(4);

        p = dn_a;
        send_frame(0, 'hA5, 8, 16, 0, 0, 1, 2'b11);
        wait_ticks(32);
        verify(0, "8n1_a5", p, 'hA5, 8, 0, 0, 0, 1, 2'b11);

        p = dn_b;
        send_frame(1, 'h03, 8, 16, 1, 1, 1, 2'b11);
        wait_ticks(32);
        verify(1, "8e1_03", p, 'h03, 8, 1, 0, 1, 1, 2'b11);

        p = dn_a;
        send_frame(0, 'h55, 8, 16, 0, 0, 1, 2'b00);
        wait_ticks(32);
        verify(0, "8n1_ferr", p, 'h55, 8, 0, 0, 0, 1, 2'b00);

        p = dn_a;
        rx_a = 1'b0;
        wait_ticks(4);
        rx_a = 1'b1;
        wait_ticks(40);
        check("glitch_no_done", dn_a, p);
        send_frame(0, 'h3C, 8, 16, 0, 0, 1, 2'b11);
        wait_ticks(32);
        verify(0, "after_glitch", p, 'h3C, 8, 0, 0, 0, 1, 2'b11);

        p = dn_a;
        rx_a = 1'b0;
        wait_ticks(3 * 10 * 16);
        verify(0, "break", p, 0, 8, 0, 0, 0, 1, 2'b00);
        rx_a = 1'b1;
        wait_ticks(40);
        check("break_single_done", dn_a, p + 1);
        p = dn_a;
        send_frame(0, 'h12, 8, 16, 0, 0, 1, 2'b11);
        wait_ticks(32);
        verify(0, "after_break", p, 'h12, 8, 0, 0, 0, 1, 2'b11);

        p = dn_a;
        dat = 'h81;
        rx_a = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_a = dat[i];
            wait_ticks(16);
        end
        rx_a = dat[4];
        wait_ticks(8);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_done", 32'(if_a.o_rx_done), 0);
        check("midrst_dout", 32'(if_a.o_dout), 0);
        check("midrst_flags", {29'd0, if_a.o_parity_err, if_a.o_frame_err, if_a.o_break}, 0);
        check("midrst_dout_b", 32'(if_b.o_dout), 0);
        rx_a = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        wait_ticks(40);
        check("midrst_no_done", dn_a, p);
        send_frame(0, 'h81, 8, 16, 0, 0, 1, 2'b11);
        wait_ticks(32);
        verify(0, "after_rst", p, 'h81, 8, 0, 0, 0, 1, 2'b11);

        // back-to-back frames, next start right after the stop bit
        for (int k = 0; k < 4; k++) begin
            p   = dn_a;
            dat = int'($urandom_range(0, 255));
            send_frame(0, dat, 8, 16, 0, 0, 1, 2'b11);
            verify(0, "b2b_a", p, dat, 8, 0, 0, 0, 1, 2'b11);
        end
        wait_ticks(32);

        for (int k = 0; k < 5; k++) begin
            p   = dn_b;
            dat = int'($urandom_range(0, 255));
            pb  = 1'($urandom_range(0, 1));
            st  = {1'b1, ($urandom_range(0, 3) != 0)};
            send_frame(1, dat, 8, 16, 1, pb, 1, st);
            wait_ticks(32);
            verify(1, "rand_b", p, dat, 8, 1, 0, pb, 1, st);
        end

        for (int k = 0; k < 6; k++) begin
            p   = dn_c;
            dat = (k == 5) ? 0 : int'($urandom_range(0, 127));
            pb  = (k == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            st  = (k == 5) ? 2'b00 : {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            send_frame(2, dat, 7, 8, 1, pb, 2, st);
            wait_ticks(16);
            verify(2, "rand_c", p, dat, 7, 1, 1, pb, 2, st);
        end

        get_out(2, n, d, pe, fe, br);
        p = dn_c;
        send_frame(2, 'h2B, 7, 8, 1, 1, 2, 2'b11);
        wait_ticks(16);
        verify(2, "c_after_brk", p, 'h2B, 7, 1, 1, 1, 2, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, meaning b_tick pulses per bit period; legal values are even numbers 8..32.
REQ-003 SHALL provide parameter PARITY_EN, default 0, meaning a parity bit follows the data (1) or no parity bit (0).
REQ-004 SHALL provide parameter PARITY_ODD, default 0, meaning odd parity (1) or even parity (0); ignored when PARITY_EN=0.
REQ-005 SHALL provide parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-006 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 Port rst: input, 1 bit, asynchronous active-low reset; the block is in reset while rst=0.
REQ-008 Port b_tick: input, 1 bit, one-clk oversampling strobe at OVERSAMPLE x baud.
REQ-009 Port rx: input, 1 bit, asynchronous serial line; idle level is high.
REQ-010 Port o_rx_done: output, 1 bit, one-clk pulse marking the end of a frame.
REQ-011 Port o_dout: output, DATA_BITS bits, last received data word.
REQ-012 Port o_parity_err: output, 1 bit, parity mismatch in the last frame.
REQ-013 Port o_frame_err: output, 1 bit, a stop bit was sampled low in the last frame.
REQ-014 Port o_break: output, 1 bit, the last frame was a break condition.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer, reset to 1; all logic below uses the synchronized value rxs.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP and BRK_WAIT.
REQ-017 SHALL keep a per-bit tick counter cnt (0..OVERSAMPLE-1) that advances only on b_tick, with H=OVERSAMPLE/2.
REQ-018 SHALL capture rxs at cnt=H-1, H and H+1; the bit value is the majority of the three captures, decided at the b_tick where cnt=H+1.
REQ-019 In IDLE, a b_tick with rxs=0 SHALL enter START with cnt=0.
REQ-020 In START, a voted 1 SHALL return to IDLE (false start) without o_rx_done and without changing any flag or o_dout.
REQ-021 Each bit period SHALL end on the b_tick where cnt=OVERSAMPLE-1; the counter then wraps to 0 and the FSM enters the next bit's state.
REQ-022 DATA SHALL shift voted bits LSB-first into an internal shift register and leave after DATA_BITS bits, to PARITY if PARITY_EN=1, else to STOP.
REQ-023 PARITY SHALL set the parity error when (XOR of data bits XOR parity bit) differs from PARITY_ODD.
REQ-024 STOP SHALL vote every stop bit and set the framing error if any voted stop bit is 0.
REQ-025 With STOP_BITS=2, the first stop bit SHALL run a full period and the second SHALL end at its decision tick.
REQ-026 With STOP_BITS=1, the frame SHALL end at the decision tick (cnt=H+1) of that stop bit.
REQ-027 On the clk after the frame-ending decision tick, o_rx_done SHALL be 1 for exactly one clk; in the same cycle o_dout, o_parity_err, o_frame_err and o_break SHALL update together.
REQ-028 o_dout and all flags SHALL hold their values until the next o_rx_done.
REQ-029 The frame SHALL be flagged as a break when all data bits, the parity bit (if present) and the stop bits vote 0: o_break=1 and o_frame_err=1, after which the FSM enters BRK_WAIT.
REQ-030 BRK_WAIT SHALL return to IDLE only after a b_tick with rxs=1.
REQ-031 Every state other than BRK_WAIT SHALL go from the frame end to IDLE, so a start edge in the second half of a stop bit is accepted (back-to-back frames).
REQ-032 b_tick SHALL be ignored in a cycle it is not asserted; no state other than the done pulse advances without b_tick.

Reset
REQ-033 While rst=0, the block SHALL hold: state=IDLE, cnt=0, synchronizer=1, o_rx_done=0, o_dout=0, o_parity_err=0, o_frame_err=0, o_break=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately with no o_rx_done pulse; after release, the block waits for a new falling edge.

Verification
REQ-035 8N1, 0xA5 sent at OVERSAMPLE=16 -> one o_rx_done pulse, o_dout=0xA5, all flags 0.
REQ-036 8E1, 0x03 sent with parity bit 1 -> o_dout=0x03, o_parity_err=1, o_frame_err=0.
REQ-037 8N1, 0x55 sent with stop bit 0 then line high -> o_dout=0x55, o_frame_err=1, o_break=0.
REQ-038 rx low for 4 ticks only -> no o_rx_done, state returns to IDLE; a following 0x3C frame is received correctly.
REQ-039 rx held low for 3 frame times -> one done with o_dout=0, o_break=1, o_frame_err=1; no further done until rx high followed by a new start.
REQ-040 rst=0 asserted at data bit 4 of a frame -> outputs at reset values, no done; next frame 0x81 received as o_dout=0x81.
